// File: rtl/ctrl_pkg.sv
// Shared definitions for the cpu_control_unit sequencer: FSM states, opcode classes, instruction fields.
// Latency: none (types, constants and pure field-extraction helpers only).
// Backpressure: n/a; optional debug port macro used by the design is CTRL_DEBUG_PORT_EN.
package ctrl_pkg;

    // Sequencer states; HALTED is only left through reset.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALTED    = 3'd4
    } state_t;

    // Datapath geometry: four 4-bit architectural registers.
    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int RADDR_W  = 2;
    localparam int OPC_W    = 3;
    localparam int IR_W     = 12;

    // Control-class opcode; the mod bit selects LDI or HALT.
    localparam logic [2:0] OP_CTRL  = 3'b111;
    localparam logic       MOD_LDI  = 1'b0;
    localparam logic       MOD_HALT = 1'b1;

    // Instruction field positions: [11:9] op, [8:7] rd, [6:5] rs, [4] mod, [3:0] imm.
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 7;
    localparam int RS_MSB  = 6;
    localparam int RS_LSB  = 5;
    localparam int MOD_BIT = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    function automatic logic [OPC_W-1:0] ir_op(input logic [IR_W-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [RADDR_W-1:0] ir_rd(input logic [IR_W-1:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [RADDR_W-1:0] ir_rs(input logic [IR_W-1:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic ir_mod(input logic [IR_W-1:0] ir);
        return ir[MOD_BIT];
    endfunction

    function automatic logic [DATA_W-1:0] ir_imm(input logic [IR_W-1:0] ir);
        return ir[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4 x 4-bit register file: synchronous write, synchronous active-low reset, combinational reads.
// Latency: write visible on the read ports the cycle after we_i; reads are zero-latency.
// Backpressure: none; optional debug read port exists only when CTRL_DEBUG_PORT_EN is defined.
module cpu_regfile
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [RADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0]  rdata_a_o,
    input  logic [RADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]  rdata_b_o
`ifdef CTRL_DEBUG_PORT_EN
    ,
    input  logic [RADDR_W-1:0] raddr_dbg_i,
    output logic [DATA_W-1:0]  rdata_dbg_o
`endif
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    // Next-state: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Storage; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand read paths (a = rd, b = rs).
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

`ifdef CTRL_DEBUG_PORT_EN
    // Independent observation port, never used by the sequencer itself.
    assign rdata_dbg_o = regs_q[raddr_dbg_i];
`else
    // No observation port: only the two operand read paths exist.
`endif

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving a 4-bit combinational ALU.
// Latency (zero fetch wait): ALU op 4 cycles, LDI 3 cycles, HALT 2 cycles to halted.
// Backpressure: waits in FETCH indefinitely for instr_valid; CTRL_DEBUG_PORT_EN adds dbg_sel/dbg_data/dbg_pc.
module cpu_control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               instr_req,
    output logic [PC_W-1:0]    instr_addr,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [3:0]         alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               carry_flag,
    output logic               zero_flag,
`ifdef CTRL_DEBUG_PORT_EN
    input  logic [1:0]         dbg_sel,
    output logic [3:0]         dbg_data,
    output logic [PC_W-1:0]    dbg_pc,
`endif
    output logic               halted
);

    // Architectural and sequencing state.
    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [OPC_W-1:0]    alu_op_q;
    logic [DATA_W-1:0]   res_q;
    logic                res_carry_q;
    logic                res_zero_q;
    logic                carry_q;
    logic                zero_q;
    logic                halted_q;

    // Decoded view of the held instruction.
    logic [OPC_W-1:0]    dec_op;
    logic [RADDR_W-1:0]  dec_rd;
    logic [RADDR_W-1:0]  dec_rs;
    logic                dec_mod;
    logic [DATA_W-1:0]   dec_imm;
    logic                dec_is_ctrl;

    // Register file hookup.
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   rf_rdata_a;
    logic [DATA_W-1:0]   rf_rdata_b;
    logic [DATA_W-1:0]   opnd_b;

    // Field extraction from IR; the encoding is fixed at 12 bits.
    always_comb begin
        dec_op      = ir_op(ir_q);
        dec_rd      = ir_rd(ir_q);
        dec_rs      = ir_rs(ir_q);
        dec_mod     = ir_mod(ir_q);
        dec_imm     = ir_imm(ir_q);
        dec_is_ctrl = (dec_op == OP_CTRL);
    end

    // Operand b mux, writeback data select and pc increment (wraps naturally).
    always_comb begin
        opnd_b   = dec_mod ? dec_imm : rf_rdata_b;
        rf_we    = (state_q == WRITEBACK);
        rf_wdata = dec_is_ctrl ? dec_imm : res_q;
        pc_d     = pc_q + PC_W'(1);
    end

    cpu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (dec_rd),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (dec_rd),
        .rdata_a_o  (rf_rdata_a),
        .raddr_b_i  (dec_rs),
        .rdata_b_o  (rf_rdata_b)
`ifdef CTRL_DEBUG_PORT_EN
        ,
        .raddr_dbg_i(dbg_sel),
        .rdata_dbg_o(dbg_data)
`endif
    );

    // Sequencer FSM with registered ALU drive, result latch, flags and halt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_q       <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instr_data;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_is_ctrl) begin
                        if (dec_mod == MOD_HALT) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else begin
                            state_q  <= WRITEBACK;
                        end
                    end else begin
                        // Operands read here, so rd==rs sees the pre-write value.
                        alu_a_q  <= rf_rdata_a;
                        alu_b_q  <= opnd_b;
                        alu_op_q <= dec_op;
                        state_q  <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    res_q       <= alu_result;
                    res_carry_q <= alu_carry;
                    res_zero_q  <= alu_zero;
                    state_q     <= WRITEBACK;
                end
                WRITEBACK: begin
                    // LDI leaves the flags alone; the register write happens in the regfile.
                    if (!dec_is_ctrl) begin
                        carry_q <= res_carry_q;
                        zero_q  <= res_zero_q;
                    end
                    pc_q    <= pc_d;
                    state_q <= FETCH;
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Fetch request is suppressed combinationally while reset is asserted.
    assign instr_req  = (state_q == FETCH) && rst_n;
    assign instr_addr = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign halted     = halted_q;

`ifdef CTRL_DEBUG_PORT_EN
    assign dbg_pc = pc_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: behavioural ALU and instruction memory around the sequencer.
// Latency: checks are sampled on the falling edge, half a cycle after each state update.
// Backpressure: instr_valid is driven by the bench to exercise fetch stalls.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [11:0] instr_data;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        carry_flag;
    logic        zero_flag;
    logic        halted;
`ifdef CTRL_DEBUG_PORT_EN
    logic [1:0]  dbg_sel = 2'd0;
    logic [3:0]  dbg_data;
    logic [7:0]  dbg_pc;
`endif

    logic [11:0] imem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, zero, result}.
    function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [4:0] t;
        logic [3:0] r;
        logic       c;
        t = 5'd0;
        r = 4'd0;
        c = 1'b0;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; c = t[4]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = {a[2:0], 1'b0}; c = a[3]; end
            3'd6: begin r = {1'b0, a[3:1]}; c = a[0]; end
            default: r = 4'd0;
        endcase
        return {c, (r == 4'd0), r};
    endfunction

    assign {alu_carry, alu_zero, alu_result} = alu_model(alu_a, alu_b, alu_opcode);
    assign instr_data = imem[instr_addr];

    cpu_control_unit #(.PC_W(8), .INSTR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
`ifdef CTRL_DEBUG_PORT_EN
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .dbg_pc     (dbg_pc),
`endif
        .halted     (halted)
    );

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic md,
                                        input logic [3:0] imm);
        return {op, rd, rs, md, imm};
    endfunction

    function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return enc(3'b111, rd, 2'd0, 1'b0, imm);
    endfunction

    function automatic logic [11:0] hlt();
        return enc(3'b111, 2'd0, 2'd0, 1'b1, 4'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = hlt();
    endtask

    task automatic do_reset(input logic vld);
        instr_valid = vld;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Bounded wait for a fetch request at the given address.
    task automatic wait_fetch(input logic [7:0] addr);
        int n;
        n = 0;
        while (!(instr_req && instr_addr == addr) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_fetch", {23'd0, instr_req, instr_addr}, {23'd0, 1'b1, addr});
    endtask

    // From a FETCH cycle with instr_valid high, run one ALU instruction and check it.
    task automatic alu_check(input string tag, input logic [1:0] rd, input logic [3:0] ea,
                             input logic [3:0] eb, input logic [2:0] eop);
        logic [5:0] m;
        m = alu_model(ea, eb, eop);
        step();
        step();
        chk({tag, "_a"}, alu_a, ea);
        chk({tag, "_b"}, alu_b, eb);
        chk({tag, "_op"}, alu_opcode, eop);
        step();
        step();
        chk({tag, "_rd"}, dut.u_regfile.regs_q[rd], m[3:0]);
        chk({tag, "_c"}, carry_flag, m[5]);
        chk({tag, "_z"}, zero_flag, m[4]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        fill_halt();

        // LDI r1,5 with instr_valid high even during reset
        imem[0] = ldi(2'd1, 4'd5);
        instr_valid = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst_req", instr_req, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_alu_op", alu_opcode, 3'd0);
        chk("rst_flags", {carry_flag, zero_flag}, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("ldi_req0", instr_req, 1'b1);
        chk("ldi_addr0", instr_addr, 8'd0);
        step();
        chk("ldi_req_fall", instr_req, 1'b0);
        step();
        chk("ldi_r1_pre", dut.u_regfile.regs_q[1], 4'd0);
        step();
        chk("ldi_req_again", instr_req, 1'b1);
        chk("ldi_pc1", instr_addr, 8'd1);
        chk("ldi_r1", dut.u_regfile.regs_q[1], 4'd5);
        chk("ldi_flags", {carry_flag, zero_flag}, 2'b00);

        // Register-register ALU ops, including rd==rs
        fill_halt();
        imem[0] = ldi(2'd1, 4'd5);
        imem[1] = ldi(2'd2, 4'd3);
        imem[2] = enc(3'd0, 2'd1, 2'd2, 1'b0, 4'd0);
        imem[3] = enc(3'd1, 2'd2, 2'd2, 1'b0, 4'd0);
        do_reset(1'b1);
        wait_fetch(8'd2);
        alu_check("add_rr", 2'd1, 4'd5, 4'd3, 3'd0);
        chk("add_pc3", instr_addr, 8'd3);
        alu_check("sub_same", 2'd2, 4'd3, 4'd3, 3'd1);

        // Immediate operand sweep over all ALU opcodes; R2 must never change
        fill_halt();
        imem[0] = ldi(2'd2, 4'd9);
        for (int k = 0; k < 7; k++) begin
            imem[1 + 2 * k] = ldi(2'd1, 4'd1);
            imem[2 + 2 * k] = enc(3'(k), 2'd1, 2'd2, 1'b1, 4'hF);
        end
        do_reset(1'b1);
        for (int k = 0; k < 7; k++) begin
            wait_fetch(8'(2 + 2 * k));
            alu_check("imm_sweep", 2'd1, 4'd1, 4'hF, 3'(k));
            chk("imm_r2", dut.u_regfile.regs_q[2], 4'd9);
        end

        // Fetch stall: five cycles without instr_valid
        fill_halt();
        imem[0] = ldi(2'd3, 4'd7);
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", instr_req, 1'b1);
            chk("stall_addr", instr_addr, 8'd0);
            step();
        end
        chk("stall_r3", dut.u_regfile.regs_q[3], 4'd0);
        instr_valid = 1'b1;
        step();
        chk("stall_accept", instr_req, 1'b0);
        step();
        step();
        chk("stall_r3_ldi", dut.u_regfile.regs_q[3], 4'd7);

        // HALT at address 2, then reset recovery
        fill_halt();
        imem[0] = ldi(2'd0, 4'd1);
        imem[1] = ldi(2'd3, 4'd2);
        imem[3] = ldi(2'd0, 4'd9);
        do_reset(1'b1);
        wait_fetch(8'd2);
        step();
        chk("halt_dec", halted, 1'b0);
        step();
        chk("halt_set", halted, 1'b1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_req) hi++;
            step();
        end
        chk("halt_no_req", hi, 0);
        chk("halt_frozen_r0", dut.u_regfile.regs_q[0], 4'd1);
        chk("halt_pc", instr_addr, 8'd2);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("halt_rst_halted", halted, 1'b0);
        chk("halt_rst_req", instr_req, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("halt_resume_req", instr_req, 1'b1);
        chk("halt_resume_pc", instr_addr, 8'd0);

        // pc wrap 254 -> 255 -> 0
        for (int i = 0; i < 256; i++) imem[i] = ldi(2'd0, 4'(i));
        do_reset(1'b1);
        wait_fetch(8'd254);
        wait_fetch(8'd255);
        wait_fetch(8'd0);
        chk("wrap_r0", dut.u_regfile.regs_q[0], 4'd15);
        chk("wrap_halted", halted, 1'b0);

        // Reset while in EXECUTE aborts the writeback
        fill_halt();
        imem[0] = ldi(2'd1, 4'd5);
        imem[1] = ldi(2'd2, 4'd3);
        imem[2] = enc(3'd0, 2'd1, 2'd2, 1'b0, 4'd0);
        do_reset(1'b1);
        wait_fetch(8'd2);
        step();
        step();
        chk("exrst_alu_a", alu_a, 4'd5);
        rst_n = 1'b0;
        step();
        chk("exrst_r0", dut.u_regfile.regs_q[0], 4'd0);
        chk("exrst_r1", dut.u_regfile.regs_q[1], 4'd0);
        chk("exrst_r2", dut.u_regfile.regs_q[2], 4'd0);
        chk("exrst_r3", dut.u_regfile.regs_q[3], 4'd0);
        chk("exrst_flags", {carry_flag, zero_flag}, 2'b00);
        chk("exrst_alu_b", alu_b, 4'd0);
        chk("exrst_req", instr_req, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("exrst_pc", instr_addr, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
